// File: rtl/word_loader.sv
`default_nettype none
// ============================================================================
// Module      : word_loader
// Description : Pulls bytes from a FWFT FIFO and loads them into a word
//               storage. A 0x00 byte terminates a word, and a word that
//               reaches WORD_MAX_LEN bytes completes without a terminator.
//               A packet that ends mid-word latches a sticky error.
// Revision    : 1.0 - initial release
// ============================================================================
module word_loader #(
  parameter int WORD_MAX_LEN = -1,
  localparam int ADDR_W = (WORD_MAX_LEN < 2) ? 1 : $clog2(WORD_MAX_LEN),
  localparam int LEN_W  = (WORD_MAX_LEN < 2) ? 2 : $clog2(WORD_MAX_LEN + 1)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        din,
  input  logic              din_empty,
  input  logic              din_pkt_end,
  output logic              din_rd_en,
  output logic [7:0]        wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  output logic              set_full,
  input  logic              storage_full,
  output logic [LEN_W-1:0]  word_len,
  output logic [15:0]       word_count,
  output logic              err
);

  typedef enum logic [1:0] {
    WAIT_EMPTY = 2'd0,
    LOAD       = 2'd1,
    COMMIT     = 2'd2,
    ERROR      = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [LEN_W-1:0]  cnt_inc;
  logic              max_hit;
  logic              cnt_clr;
  logic              term_seen;
  logic              word_done;

  // Byte count after the current write, widened so a full word fits.
  assign cnt_inc = LEN_W'(cnt) + LEN_W'(1);
  assign max_hit = (cnt_inc == LEN_W'(WORD_MAX_LEN));

  assign wr_data = din;
  assign wr_addr = cnt;
  assign err     = (state == ERROR);

  // Next-state decode and strobes; every strobe is held low while RESET is high.
  always_comb begin
    state_nxt = state;
    din_rd_en = 1'b0;
    wr_en     = 1'b0;
    set_full  = 1'b0;
    cnt_clr   = 1'b0;
    term_seen = 1'b0;
    word_done = 1'b0;
    case (state)
      WAIT_EMPTY: begin
        if (!storage_full) begin
          cnt_clr   = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (!din_empty) begin
          din_rd_en = 1'b1;
          if (din == 8'h00) begin
            term_seen = 1'b1;
            state_nxt = COMMIT;
          end else begin
            wr_en = 1'b1;
            if (max_hit) begin
              word_done = 1'b1;
              state_nxt = COMMIT;
            end else if (din_pkt_end) begin
              state_nxt = ERROR;
            end
          end
        end
      end
      COMMIT: begin
        set_full  = 1'b1;
        state_nxt = WAIT_EMPTY;
      end
      ERROR: begin
        state_nxt = ERROR;
      end
      default: begin
        state_nxt = WAIT_EMPTY;
      end
    endcase
    if (RESET) begin
      din_rd_en = 1'b0;
      wr_en     = 1'b0;
      set_full  = 1'b0;
      term_seen = 1'b0;
      word_done = 1'b0;
      cnt_clr   = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= WAIT_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Byte counter, committed length and word counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt        <= '0;
      word_len   <= '0;
      word_count <= '0;
    end else begin
      if (cnt_clr) begin
        cnt <= '0;
      end else if (wr_en && !word_done) begin
        // A completing write leaves cnt alone; it is cleared before the next word.
        cnt <= cnt + ADDR_W'(1);
      end
      if (term_seen) begin
        word_len <= LEN_W'(cnt);
      end else if (word_done) begin
        word_len <= LEN_W'(WORD_MAX_LEN);
      end
      if (set_full) begin
        word_count <= word_count + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire
